// File: rtl/zbtram_pkg.sv
// Shared encodings for the ZBT SSRAM AHB slave: FSM states, response codes,
// and the AHB size/transfer-type codes used by the data path.
package zbtram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } zbt_state_e;

    localparam logic RSP_OKAY  = 1'b0;
    localparam logic RSP_ERROR = 1'b1;

    localparam logic [1:0] HSIZE_BYTE  = 2'b00;
    localparam logic [1:0] HSIZE_HALF  = 2'b01;
    localparam logic [1:0] HSIZE_WORD  = 2'b10;
    localparam logic [1:0] HSIZE_DWORD = 2'b11;   // wider than the 32-bit bus

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/ahb_align_chk.sv
// Combinational illegal-transfer decode for a 32-bit AHB SRAM slave:
// oversize transfers and misaligned halfword/word accesses are flagged.
module ahb_align_chk
    import zbtram_pkg::*;
(
    input  logic [1:0] hsize,
    input  logic [1:0] haddr,
    output logic       bad
);

    // Byte accesses are always aligned; wider ones need zero low address bits.
    always_comb begin
        bad = 1'b0;
        case (hsize)
            HSIZE_BYTE:  bad = 1'b0;
            HSIZE_HALF:  bad = haddr[0];
            HSIZE_WORD:  bad = (haddr != 2'b00);
            HSIZE_DWORD: bad = 1'b1;
            default:     bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_zbtram_dpath_32.sv
// AHB data path and response stage for the 32-bit ZBT SSRAM interface.
// Write data goes straight to the pads; read data is either passed through
// (RD_WAIT=0) or captured into rdcap behind one wait state (RD_WAIT=1).
// Illegal transfers get the two-cycle ERROR response and assert ERRKILL so
// the top level can suppress the byte write strobes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready, OKAY; no wait or error in progress
// RD1   | registered-read wait state, SDATAIN captured at end of cycle
// RD2   | registered-read completion, rdcap on HRDATA
// ERR1  | first ERROR cycle (not ready)
// ERR2  | second ERROR cycle (ready)
module ahb_zbtram_dpath_32
    import zbtram_pkg::*;
#(
    parameter int RD_WAIT = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSELSSRAM,
    input  logic        HREADYIn,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [1:0]  HSIZE,
    input  logic [1:0]  HADDR,
    input  logic [31:0] HWDATA,
    input  logic [31:0] SDATAIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOut,
    output logic        HRESP,
    output logic [31:0] SDATAOUT,
    output logic        SDATAOE,
    output logic        ERRKILL
);

    localparam bit RD_REG = (RD_WAIT == 1);

    zbt_state_e  state;
    zbt_state_e  state_nxt;
    logic        trans_valid;
    logic        bad;
    logic        wr_dp;
    logic        rd_dp;
    logic        rdcap_load;
    logic [31:0] rdcap;

    ahb_align_chk u_align_chk (
        .hsize (HSIZE),
        .haddr (HADDR),
        .bad   (bad)
    );

    // Address-phase qualification: only NONSEQ/SEQ with the mux ready count.
    always_comb begin
        trans_valid = HSELSSRAM && HREADYIn &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
        ERRKILL     = trans_valid && bad;
    end

    // State register and data-phase flags; flags only advance on HREADYIn.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
            wr_dp <= 1'b0;
            rd_dp <= 1'b0;
        end else begin
            state <= state_nxt;
            if (HREADYIn) begin
                wr_dp <= trans_valid && HWRITE && !bad;
                rd_dp <= trans_valid && !HWRITE && !bad;
            end
        end
    end

    // Next state and response outputs; ready states accept a new address
    // only while the mux reports HREADYIn.
    always_comb begin
        state_nxt = state;
        HREADYOut = 1'b1;
        HRESP     = RSP_OKAY;
        case (state)
            ST_IDLE, ST_RD2, ST_ERR2: begin
                if (state == ST_ERR2) begin
                    HRESP = RSP_ERROR;
                end
                if (HREADYIn) begin
                    if (trans_valid && bad) begin
                        state_nxt = ST_ERR1;
                    end else if (trans_valid && !HWRITE && RD_REG) begin
                        state_nxt = ST_RD1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RD1: begin
                HREADYOut = 1'b0;
                state_nxt = ST_RD2;
            end
            ST_ERR1: begin
                HREADYOut = 1'b0;
                HRESP     = RSP_ERROR;
                state_nxt = ST_ERR2;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pass-through mode shadows every read data phase so HRDATA keeps the
    // last read value once rd_dp drops.
    always_comb begin
        rdcap_load = RD_REG ? (state == ST_RD1) : rd_dp;
    end

    // Read capture register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rdcap <= '0;
        end else if (rdcap_load) begin
            rdcap <= SDATAIN;
        end
    end

    // Read return mux and write pad drive.
    always_comb begin
        HRDATA   = (!RD_REG && rd_dp) ? SDATAIN : rdcap;
        SDATAOUT = HWDATA;
        SDATAOE  = wr_dp;
    end

endmodule

// File: tb/tb_ahb_zbtram_dpath_32.sv
// Directed bench: a vector table for the pass-through instance, plus
// hand-written multi-cycle sequences for the registered-read instance.
module tb_ahb_zbtram_dpath_32;

    logic        clk = 1'b0;
    logic        hrst;
    logic        hsel;
    logic        hrdy;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [1:0]  hsize;
    logic [1:0]  haddr;
    logic [31:0] hwdata;
    logic [31:0] sdatain;

    logic [31:0] hrdata0, sdataout0, hrdata1, sdataout1;
    logic        hready0, hresp0, oe0, kill0;
    logic        hready1, hresp1, oe1, kill1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ahb_zbtram_dpath_32 #(.RD_WAIT(0)) dut0 (
        .HCLK(clk), .HRESET(hrst), .HSELSSRAM(hsel), .HREADYIn(hrdy),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HADDR(haddr),
        .HWDATA(hwdata), .SDATAIN(sdatain), .HRDATA(hrdata0),
        .HREADYOut(hready0), .HRESP(hresp0), .SDATAOUT(sdataout0),
        .SDATAOE(oe0), .ERRKILL(kill0)
    );

    ahb_zbtram_dpath_32 #(.RD_WAIT(1)) dut1 (
        .HCLK(clk), .HRESET(hrst), .HSELSSRAM(hsel), .HREADYIn(hrdy),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HADDR(haddr),
        .HWDATA(hwdata), .SDATAIN(sdatain), .HRDATA(hrdata1),
        .HREADYOut(hready1), .HRESP(hresp1), .SDATAOUT(sdataout1),
        .SDATAOE(oe1), .ERRKILL(kill1)
    );

    typedef struct {
        string       name;
        logic        hsel;
        logic        hrdy;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [1:0]  hsize;
        logic [1:0]  haddr;
        logic [31:0] hwdata;
        logic [31:0] sdatain;
        logic        e_kill;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_rdata;
        logic        e_oe;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic s, input logic r, input logic [1:0] t,
                       input logic w, input logic [1:0] sz, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] sd, input logic ek,
                       input logic er, input logic ep, input logic [31:0] erd, input logic eo);
        vec_t v;
        v = '{nm, s, r, t, w, sz, a, wd, sd, ek, er, ep, erd, eo};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic r, input logic [1:0] t, input logic w,
                         input logic [1:0] sz, input logic [1:0] a, input logic [31:0] wd,
                         input logic [31:0] sd);
        hsel = s; hrdy = r; htrans = t; hwrite = w;
        hsize = sz; haddr = a; hwdata = wd; sdatain = sd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        hrst = 1'b1;
        drive(0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        hrst = 1'b0;
    endtask

    initial begin
        hrst = 1'b1;
        drive(0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0, 32'h0);

        //   name            sel rdy trn wr sz     ad     hwdata        sdatain       kill rdy rsp hrdata        oe
        add("rst_idle",      0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 1, 0, 32'h0,        0);
        add("rd_addr",       1, 1, 2'b10, 0, 2'b10, 2'b00, 32'h0,        32'hA5A51234, 0, 1, 0, 32'h0,        0);
        add("rd_data",       0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'hA5A51234, 0, 1, 0, 32'hA5A51234, 0);
        add("rd_hold",       0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0BAD0BAD, 0, 1, 0, 32'hA5A51234, 0);
        add("wr_addr",       1, 1, 2'b10, 1, 2'b10, 2'b00, 32'h0,        32'h0,        0, 1, 0, 32'hA5A51234, 0);
        add("wr_data",       0, 1, 2'b00, 0, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0,        0, 1, 0, 32'hA5A51234, 1);
        add("wr_after",      0, 1, 2'b00, 0, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0,        0, 1, 0, 32'hA5A51234, 0);
        add("wr2_addr",      1, 1, 2'b10, 1, 2'b10, 2'b00, 32'h0,        32'h0,        0, 1, 0, 32'hA5A51234, 0);
        add("w2r_addr",      1, 1, 2'b11, 0, 2'b10, 2'b00, 32'h12345678, 32'h0,        0, 1, 0, 32'hA5A51234, 1);
        add("w2r_data",      0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'hCAFEF00D, 0, 1, 0, 32'hCAFEF00D, 0);
        add("hw_bad_addr",   1, 1, 2'b10, 1, 2'b01, 2'b01, 32'h0,        32'h0,        1, 1, 0, 32'hCAFEF00D, 0);
        add("hw_bad_err1",   0, 0, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 0, 1, 32'hCAFEF00D, 0);
        add("hw_bad_err2",   0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 1, 1, 32'hCAFEF00D, 0);
        add("err_done",      0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 1, 0, 32'hCAFEF00D, 0);
        add("byte_rd_a3",    1, 1, 2'b10, 0, 2'b00, 2'b11, 32'h0,        32'h0,        0, 1, 0, 32'hCAFEF00D, 0);
        add("byte_rd_data",  0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h000000AB, 0, 1, 0, 32'h000000AB, 0);
        add("hw_rd_a2",      1, 1, 2'b10, 0, 2'b01, 2'b10, 32'h0,        32'h0,        0, 1, 0, 32'h000000AB, 0);
        add("hw_rd_data",    0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h00007777, 0, 1, 0, 32'h00007777, 0);
        add("bad_not_ready", 1, 0, 2'b10, 0, 2'b11, 2'b00, 32'h0,        32'h0,        0, 1, 0, 32'h00007777, 0);
        add("busy_bad",      1, 1, 2'b01, 0, 2'b11, 2'b00, 32'h0,        32'h0,        0, 1, 0, 32'h00007777, 0);
        add("after_busy",    0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 1, 0, 32'h00007777, 0);
        add("wd_bad_a2",     1, 1, 2'b10, 0, 2'b10, 2'b10, 32'h0,        32'h0,        1, 1, 0, 32'h00007777, 0);
        add("wd_bad_err1",   1, 0, 2'b10, 0, 2'b10, 2'b00, 32'h0,        32'h0,        0, 0, 1, 32'h00007777, 0);
        add("err2_new_rd",   1, 1, 2'b10, 0, 2'b10, 2'b00, 32'h0,        32'h0,        0, 1, 1, 32'h00007777, 0);
        add("err2_rd_data",  0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0,        32'h31415926, 0, 1, 0, 32'h31415926, 0);

        do_reset();

        // Vector table against the pass-through instance.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].hsel, vecs[i].hrdy, vecs[i].htrans, vecs[i].hwrite,
                  vecs[i].hsize, vecs[i].haddr, vecs[i].hwdata, vecs[i].sdatain);
            @(negedge clk);
            check({vecs[i].name, ".errkill"},  {31'h0, kill0},   {31'h0, vecs[i].e_kill});
            check({vecs[i].name, ".hready"},   {31'h0, hready0}, {31'h0, vecs[i].e_rdy});
            check({vecs[i].name, ".hresp"},    {31'h0, hresp0},  {31'h0, vecs[i].e_resp});
            check({vecs[i].name, ".hrdata"},   hrdata0,          vecs[i].e_rdata);
            check({vecs[i].name, ".sdataoe"},  {31'h0, oe0},     {31'h0, vecs[i].e_oe});
            check({vecs[i].name, ".sdataout"}, sdataout0,        vecs[i].hwdata);
            next_cycle();
        end

        // Registered reads, back to back; the bench plays the slave mux.
        do_reset();
        drive(1, 1, 2'b10, 0, 2'b10, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check("rw1_addr1.hready", {31'h0, hready1}, 32'h1);
        next_cycle();
        drive(1, 0, 2'b10, 0, 2'b10, 2'b00, 32'h0, 32'h11111111);
        @(negedge clk);
        check("rw1_rd1a.hready", {31'h0, hready1}, 32'h0);
        check("rw1_rd1a.hresp",  {31'h0, hresp1},  32'h0);
        next_cycle();
        drive(1, 1, 2'b10, 0, 2'b10, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check("rw1_rd2a.hready", {31'h0, hready1}, 32'h1);
        check("rw1_rd2a.hrdata", hrdata1, 32'h11111111);
        next_cycle();
        drive(0, 0, 2'b00, 0, 2'b00, 2'b00, 32'h0, 32'h22222222);
        @(negedge clk);
        check("rw1_rd1b.hready", {31'h0, hready1}, 32'h0);
        check("rw1_rd1b.hrdata", hrdata1, 32'h11111111);
        next_cycle();
        drive(0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check("rw1_rd2b.hready", {31'h0, hready1}, 32'h1);
        check("rw1_rd2b.hrdata", hrdata1, 32'h22222222);
        check("rw1_rd2b.sdataoe", {31'h0, oe1}, 32'h0);
        next_cycle();
        @(negedge clk);
        check("rw1_idle.hready", {31'h0, hready1}, 32'h1);
        check("rw1_idle.hrdata", hrdata1, 32'h22222222);

        // Oversize read, master cancels during ERR2.
        next_cycle();
        drive(1, 1, 2'b10, 0, 2'b11, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check("dw_addr.errkill", {31'h0, kill1}, 32'h1);
        next_cycle();
        drive(0, 0, 2'b00, 0, 2'b00, 2'b00, 32'h0, 32'h99999999);
        @(negedge clk);
        check("dw_err1.hready", {31'h0, hready1}, 32'h0);
        check("dw_err1.hresp",  {31'h0, hresp1},  32'h1);
        check("dw_err1.hrdata", hrdata1, 32'h22222222);
        check("dw_err1.sdataoe", {31'h0, oe1}, 32'h0);
        next_cycle();
        drive(0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0, 32'h99999999);
        @(negedge clk);
        check("dw_err2.hready", {31'h0, hready1}, 32'h1);
        check("dw_err2.hresp",  {31'h0, hresp1},  32'h1);
        next_cycle();
        @(negedge clk);
        check("dw_idle.hready", {31'h0, hready1}, 32'h1);
        check("dw_idle.hresp",  {31'h0, hresp1},  32'h0);
        check("dw_idle.hrdata", hrdata1, 32'h22222222);

        // Reset arriving in RD1 abandons the wait state.
        next_cycle();
        drive(1, 1, 2'b10, 0, 2'b10, 2'b00, 32'h0, 32'h0);
        next_cycle();
        hrst = 1'b1;
        drive(0, 0, 2'b00, 0, 2'b00, 2'b00, 32'h0, 32'h55555555);
        @(negedge clk);
        check("rst_rd1.hready", {31'h0, hready1}, 32'h0);
        next_cycle();
        hrst = 1'b0;
        drive(0, 1, 2'b00, 0, 2'b00, 2'b00, 32'h0, 32'h55555555);
        @(negedge clk);
        check("rst_after.hready",  {31'h0, hready1}, 32'h1);
        check("rst_after.hresp",   {31'h0, hresp1},  32'h0);
        check("rst_after.hrdata",  hrdata1, 32'h0);
        check("rst_after.sdataoe", {31'h0, oe1}, 32'h0);
        check("rst_after.hrdata0", hrdata0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
